// File: rtl/tt_mask_idx_agen.sv
// -----------------------------------------------------------------------------
// tt_mask_idx_agen
// Consumes the mask/index item stream of the vector memop mask FSM and turns
// it into per-element LSU requests. Items (65 bits plus a last flag) are held
// in a small FIFO. One credit is returned for every item popped. Masked-off
// elements retire silently. Addresses are base+index for indexed ops and a
// running base+i*stride for strided/unit ops. o_done pulses once every
// element up to vl has retired.
//
// Optional feature: define TT_AGEN_SKIP_ZERO_WORD_EN so that a strided masked
// op retires the rest of an all-zero mask window (clipped to vl) in one
// cycle. The request stream is the same either way; only cycle counts change.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start .. i_stride       op descriptor, sampled in IDLE on i_start
//   i_mask_idx_*              credit-based item input (no ready)
//   o_mask_idx_credit         registered pulse, one per popped item
//   o_req_valid/addr/elem     element request, held until i_req_ready
//   o_busy, o_done            op in flight / one-cycle completion pulse
// -----------------------------------------------------------------------------
module tt_mask_idx_agen #(
   parameter int VLEN         = 256,
   parameter int MASK_CREDITS = 2,
   parameter int ADDR_W       = 64
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic                       i_is_indexed,
   input  logic                       i_is_masked,
   input  logic [$clog2(VLEN+1)-1:0]  i_vl,
   input  logic [ADDR_W-1:0]          i_base_addr,
   input  logic [ADDR_W-1:0]          i_stride,
   input  logic                       i_mask_idx_valid,
   input  logic [64:0]                i_mask_idx_item,
   input  logic                       i_mask_idx_last_idx,
   output logic                       o_mask_idx_credit,
   output logic                       o_req_valid,
   input  logic                       i_req_ready,
   output logic [ADDR_W-1:0]          o_req_addr,
   output logic [$clog2(VLEN)-1:0]    o_req_elem,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int VL_W  = $clog2(VLEN+1);
   localparam int EL_W  = $clog2(VLEN);
   localparam int PTR_W = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
   localparam int CNT_W = $clog2(MASK_CREDITS+1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   // ---------------- item FIFO ----------------
   logic [65:0]      fifo_mem [MASK_CREDITS];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_empty, fifo_full, push, pop;
   logic             credit_q;
   logic [65:0]      head;
   logic [63:0]      head_item;
   logic             head_mbit, head_last;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MASK_CREDITS-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push       = i_mask_idx_valid;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_W'(MASK_CREDITS));
   assign head       = fifo_mem[rd_ptr];
   assign head_item  = head[63:0];
   assign head_mbit  = head[64];
   assign head_last  = head[65];

   always_ff @(posedge i_clk) begin
      if (push && !i_reset) fifo_mem[wr_ptr] <= {i_mask_idx_last_idx, i_mask_idx_item};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         credit_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         credit_q <= pop;
      end
   end

   // ---------------- op state ----------------
   state_t            state;
   logic              busy_q, done_q;
   logic              is_indexed_q, is_masked_q;
   logic [VL_W-1:0]   vl_q, elem_q;
   logic [ADDR_W-1:0] base_q, stride_q, acc_q;

   logic              run, need_item, have_item, elem_active, retire, skip, fin;
   logic [5:0]        bit_off;
   logic [VL_W-1:0]   step, elem_nxt;
   logic [ADDR_W-1:0] acc_inc;

   assign run       = (state == ST_RUN);
   // Unmasked strided ops never touch the FIFO; everything else walks items.
   assign need_item = is_indexed_q | is_masked_q;
   assign have_item = !need_item | !fifo_empty;
   assign bit_off   = elem_q[5:0];
   assign elem_active = !is_masked_q | (is_indexed_q ? head_mbit : head_item[bit_off]);

`ifdef TT_AGEN_SKIP_ZERO_WORD_EN
   localparam int SW = VL_W + 7;
   logic [SW-1:0] to_end, remain, span;
   logic [63:0]   win;
   // Window = bits of the current word from bit_off up, clipped to vl.
   assign to_end = SW'(7'd64 - {1'b0, bit_off});
   assign remain = SW'(vl_q - elem_q);
   assign span   = (to_end < remain) ? to_end : remain;
   assign win    = (span >= SW'(64)) ? '1 : ((64'd1 << span) - 64'd1);
   assign skip   = run & is_masked_q & !is_indexed_q & !fifo_empty &
                   (((head_item >> bit_off) & win) == '0);
   assign step    = skip ? VL_W'(span) : VL_W'(1);
   assign acc_inc = skip ? stride_q * ADDR_W'(span) : stride_q;
`else
   assign skip    = 1'b0;
   assign step    = VL_W'(1);
   assign acc_inc = stride_q;
`endif

   assign retire   = (run & have_item & (!elem_active | i_req_ready)) | skip;
   assign elem_nxt = elem_q + step;
   assign fin      = (elem_nxt == vl_q);
   // Mask words pop when the walk crosses into the next word or finishes;
   // index items pop with their element.
   assign pop = retire & need_item & (is_indexed_q | (elem_nxt[5:0] == 6'd0) | fin);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         is_indexed_q <= 1'b0;
         is_masked_q  <= 1'b0;
         vl_q         <= '0;
         elem_q       <= '0;
         base_q       <= '0;
         stride_q     <= '0;
         acc_q        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  is_indexed_q <= i_is_indexed;
                  is_masked_q  <= i_is_masked;
                  vl_q         <= i_vl;
                  base_q       <= i_base_addr;
                  stride_q     <= i_stride;
                  elem_q       <= '0;
                  acc_q        <= i_base_addr;
                  busy_q       <= 1'b1;
                  if (i_vl == '0) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (retire) begin
                  elem_q <= elem_nxt;
                  acc_q  <= acc_q + acc_inc;
                  if (fin) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Protocol checks: no overflow writes; last flag marks the op's final item.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         assert (!(push && fifo_full && !pop));
         if (pop) assert (head_last == fin);
      end
   end

   assign o_mask_idx_credit = credit_q;
   assign o_req_valid       = run & have_item & elem_active;
   assign o_req_addr        = is_indexed_q ? base_q + ADDR_W'(head_item) : acc_q;
   assign o_req_elem        = elem_q[EL_W-1:0];
   assign o_busy            = busy_q;
   assign o_done            = done_q;

endmodule

// File: tb/tb_tt_mask_idx_agen.sv
module tb_tt_mask_idx_agen;

   localparam int VLEN = 256;
   localparam int MC   = 2;
   localparam int AW   = 64;
   localparam int VL_W = $clog2(VLEN+1);
   localparam int EL_W = $clog2(VLEN);

   logic            i_clk = 1'b0;
   logic            i_reset;
   logic            i_start, i_is_indexed, i_is_masked;
   logic [VL_W-1:0] i_vl;
   logic [AW-1:0]   i_base_addr, i_stride;
   logic            i_mask_idx_valid;
   logic [64:0]     i_mask_idx_item;
   logic            i_mask_idx_last_idx;
   logic            o_mask_idx_credit, o_req_valid, i_req_ready;
   logic [AW-1:0]   o_req_addr;
   logic [EL_W-1:0] o_req_elem;
   logic            o_busy, o_done;

   tt_mask_idx_agen #(.VLEN(VLEN), .MASK_CREDITS(MC), .ADDR_W(AW)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
      .i_is_indexed(i_is_indexed), .i_is_masked(i_is_masked), .i_vl(i_vl),
      .i_base_addr(i_base_addr), .i_stride(i_stride),
      .i_mask_idx_valid(i_mask_idx_valid), .i_mask_idx_item(i_mask_idx_item),
      .i_mask_idx_last_idx(i_mask_idx_last_idx), .o_mask_idx_credit(o_mask_idx_credit),
      .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
      .o_req_elem(o_req_elem), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int t0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---- upstream model: credit-limited pusher, runs at posedge+1 ----
   logic [65:0] pq[$];
   initial begin
      int pidx, cred;
      pidx = 0; cred = MC;
      i_mask_idx_valid = 1'b0; i_mask_idx_item = '0; i_mask_idx_last_idx = 1'b0;
      forever begin
         @(posedge i_clk); #1;
         if (i_reset) begin
            cred = MC; pidx = pq.size(); i_mask_idx_valid = 1'b0;
         end else begin
            if (o_mask_idx_credit) cred++;
            if (pidx < pq.size() && cred > 0) begin
               {i_mask_idx_last_idx, i_mask_idx_item} = pq[pidx];
               i_mask_idx_valid = 1'b1;
               pidx++; cred--;
            end else begin
               i_mask_idx_valid = 1'b0;
            end
         end
      end
   end

   // ---- monitor at negedge: accepted requests, credits, done ----
   logic [63:0] q_addr[$];
   int          q_elem[$], q_cyc[$];
   int          cred_cnt = 0, done_cnt = 0, done_cyc = 0;
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_req_valid && i_req_ready) begin
            q_addr.push_back(o_req_addr); q_elem.push_back(int'(o_req_elem)); q_cyc.push_back(cyc);
         end
         if (o_mask_idx_credit) cred_cnt++;
         if (o_done) begin done_cnt++; done_cyc = cyc; end
      end
   end

   task automatic step();
      @(posedge i_clk); #2;
   endtask

   task automatic start_op(input bit idx, input bit msk, input int vl,
                           input logic [63:0] base, input logic [63:0] stride);
      i_is_indexed = idx; i_is_masked = msk; i_vl = VL_W'(vl);
      i_base_addr = base; i_stride = stride; i_start = 1'b1; t0 = cyc;
      step();
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (o_busy && n < budget) begin step(); n++; end
      chk(tag, 64'(o_busy), 64'd0);
   endtask

   function automatic logic [63:0] qa(input int i);
      return (i < q_addr.size()) ? q_addr[i] : 64'hDEAD_BEEF;
   endfunction
   function automatic int qe(input int i);
      return (i < q_elem.size()) ? q_elem[i] : -1;
   endfunction
   function automatic int qc(input int i);
      return (i < q_cyc.size()) ? q_cyc[i] - t0 : -1;
   endfunction

   // Unmasked strided vl=4: four back-to-back requests, no credits, done one cycle later.
   task automatic t_unit(input string tag);
      int qb, cb, db;
      qb = q_addr.size(); cb = cred_cnt; db = done_cnt;
      start_op(0, 0, 4, 64'h1000, 64'd8);
      wait_idle({tag, "_timeout"}, 50);
      chk({tag, "_nreq"}, 64'(q_addr.size() - qb), 64'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_addr%0d", tag, k), qa(qb+k), 64'h1000 + 64'(8*k));
         chk($sformatf("%s_cyc%0d", tag, k), 64'(qc(qb+k)), 64'(k+1));
      end
      chk({tag, "_cred"}, 64'(cred_cnt - cb), 64'd0);
      chk({tag, "_ndone"}, 64'(done_cnt - db), 64'd1);
      chk({tag, "_donecyc"}, 64'(done_cyc - t0), 64'd5);
   endtask

   initial begin
      int qb, cb, db;
      int exp_c[3];
      int exp_done;
      i_reset = 1'b1; i_start = 1'b0; i_is_indexed = 1'b0; i_is_masked = 1'b0;
      i_vl = '0; i_base_addr = '0; i_stride = '0; i_req_ready = 1'b1;
      repeat (3) step();
      chk("rst_valid", 64'(o_req_valid), 0);
      chk("rst_busy",  64'(o_busy), 0);
      chk("rst_done",  64'(o_done), 0);
      chk("rst_cred",  64'(o_mask_idx_credit), 0);
      chk("rst_addr",  o_req_addr, 0);
      chk("rst_elem",  64'(o_req_elem), 0);
      i_reset = 1'b0;
      step();

      // 1: unmasked strided
      t_unit("t1");

      // 2: indexed masked, elem1 masked off
      qb = q_addr.size(); cb = cred_cnt; db = done_cnt;
      pq.push_back({1'b0, 1'b1, 64'h40});
      pq.push_back({1'b0, 1'b0, 64'h80});
      pq.push_back({1'b1, 1'b1, 64'hC0});
      start_op(1, 1, 3, 64'h2000, 64'd0);
      wait_idle("t2_timeout", 50);
      repeat (2) step();
      chk("t2_nreq",  64'(q_addr.size() - qb), 2);
      chk("t2_addr0", qa(qb), 64'h2040);
      chk("t2_elem0", 64'(qe(qb)), 0);
      chk("t2_addr1", qa(qb+1), 64'h20C0);
      chk("t2_elem1", 64'(qe(qb+1)), 2);
      chk("t2_cred",  64'(cred_cnt - cb), 3);
      chk("t2_ndone", 64'(done_cnt - db), 1);

      // 3: strided masked, vl=70 spanning two mask words
      qb = q_addr.size(); cb = cred_cnt; db = done_cnt;
      pq.push_back({1'b0, 1'b0, 64'h5});
      pq.push_back({1'b1, 1'b0, 64'h2});
      repeat (4) step();
      start_op(0, 1, 70, 64'h3000, 64'd4);
`ifdef TT_AGEN_SKIP_ZERO_WORD_EN
      exp_c = '{1, 3, 6}; exp_done = 8;
`else
      exp_c = '{1, 3, 66}; exp_done = 71;
`endif
      wait_idle("t3_timeout", 200);
      repeat (2) step();
      chk("t3_nreq",  64'(q_addr.size() - qb), 3);
      chk("t3_addr0", qa(qb),   64'h3000);
      chk("t3_addr1", qa(qb+1), 64'h3008);
      chk("t3_addr2", qa(qb+2), 64'h3104);
      chk("t3_elem2", 64'(qe(qb+2)), 65);
      for (int k = 0; k < 3; k++)
         chk($sformatf("t3_cyc%0d", k), 64'(qc(qb+k)), 64'(exp_c[k]));
      chk("t3_donecyc", 64'(done_cyc - t0), 64'(exp_done));
      chk("t3_cred",  64'(cred_cnt - cb), 2);
      chk("t3_ndone", 64'(done_cnt - db), 1);

      // 4: backpressure on an indexed request
      qb = q_addr.size(); cb = cred_cnt;
      i_req_ready = 1'b0;
      pq.push_back({1'b1, 1'b0, 64'h8});
      repeat (3) step();
      start_op(1, 0, 1, 64'h4000, 64'd0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4_valid%0d", k), 64'(o_req_valid), 1);
         chk($sformatf("t4_addr%0d", k), o_req_addr, 64'h4008);
         chk($sformatf("t4_elem%0d", k), 64'(o_req_elem), 0);
         chk($sformatf("t4_cred%0d", k), 64'(cred_cnt - cb), 0);
         step();
      end
      i_req_ready = 1'b1;
      wait_idle("t4_timeout", 20);
      chk("t4_nreq", 64'(q_addr.size() - qb), 1);
      chk("t4_acccyc", 64'(qc(qb)), 6);
      chk("t4_credend", 64'(cred_cnt - cb), 1);

      // 5a: vl=0
      qb = q_addr.size(); cb = cred_cnt; db = done_cnt;
      start_op(0, 0, 0, 64'h7000, 64'd4);
      chk("t5_done", 64'(o_done), 1);
      chk("t5_busy", 64'(o_busy), 1);
      wait_idle("t5_timeout", 10);
      chk("t5_ndone", 64'(done_cnt - db), 1);
      chk("t5_donecyc", 64'(done_cyc - t0), 1);
      chk("t5_nreq", 64'(q_addr.size() - qb), 0);
      chk("t5_cred", 64'(cred_cnt - cb), 0);

      // 5b: start while busy ignored
      qb = q_addr.size(); db = done_cnt;
      start_op(0, 0, 2, 64'h5000, 64'd4);
      i_start = 1'b1; i_vl = '0; i_base_addr = 64'h9000;
      step();
      i_start = 1'b0;
      wait_idle("t5b_timeout", 20);
      chk("t5b_nreq", 64'(q_addr.size() - qb), 2);
      chk("t5b_addr1", qa(qb+1), 64'h5004);
      chk("t5b_ndone", 64'(done_cnt - db), 1);
      chk("t5b_donecyc", 64'(done_cyc - t0), 3);

      // 6: reset mid-op with FIFO full
      i_req_ready = 1'b0;
      pq.push_back({1'b0, 1'b0, 64'h10});
      pq.push_back({1'b0, 1'b0, 64'h20});
      repeat (3) step();
      start_op(1, 0, 3, 64'h6000, 64'd0);
      chk("t6_valid_pre", 64'(o_req_valid), 1);
      db = done_cnt;
      i_reset = 1'b1;
      step();
      chk("t6_valid", 64'(o_req_valid), 0);
      chk("t6_busy",  64'(o_busy), 0);
      chk("t6_done",  64'(o_done), 0);
      chk("t6_cred",  64'(o_mask_idx_credit), 0);
      chk("t6_addr",  o_req_addr, 0);
      i_reset = 1'b0;
      i_req_ready = 1'b1;
      repeat (2) step();
      chk("t6_ndone", 64'(done_cnt - db), 0);
      t_unit("t6r");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
